channel_proc: RTL and testbench

//  Per-channel 4-bit value store for the VGA control path. Holds four 4-bit

---
 rtl/channel_proc.sv | 128 ++++++++++++
 tb/tb_channel_proc.sv | 289 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/channel_proc.sv
// channel_proc: four 4-bit channel values for the VGA control path.
// The board switches SW1:SW0 select one channel. A command write
// (address/data/valid) loads the selected channel, and an edge-detected
// "add" request increments it. Every update of the selected value is
// presented on data_out with a one-cycle data_out_valid strobe.
// Optional build macro SATURATE_ADD_EN: when defined, add stops at the
// all-ones value instead of wrapping to zero.
module channel_proc #(
    parameter logic [3:0] CMD_ADDR = 4'h2,
    parameter int          WIDTH    = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             SW0,
    input  logic             SW1,
    input  logic             add,
    input  logic [3:0]       address,
    input  logic [WIDTH-1:0] data,
    input  logic             valid,
    output logic             ack,
    output logic [WIDTH-1:0] data_out,
    output logic             data_out_valid,
    output logic [1:0]       channel
);

    logic [1:0]       swMeta_q;
    logic [1:0]       swSync_q;
    logic [1:0]       selPrev_q;
    logic             validS_q;
    logic             validDly_q;
    logic             addS_q;
    logic             addDly_q;
    logic [3:0]       addrS_q;
    logic [WIDTH-1:0] dataS_q;
    logic [WIDTH-1:0] chan_q [4];
    logic [WIDTH-1:0] chan_d [4];
    logic             ack_q;
    logic             ack_d;
    logic [WIDTH-1:0] dataOut_q;
    logic [WIDTH-1:0] dataOut_d;
    logic             dataOutValid_q;
    logic             dataOutValid_d;

    logic [1:0]       sel;
    logic             cmdEvent;
    logic             cmdHit;
    logic             addEvent;
    logic             selChanged;
    logic [WIDTH-1:0] curVal;
    logic [WIDTH-1:0] incVal;

    // The select is the synchronized switch value. Events are rising edges
    // of the sampled strobes, compared against a one-cycle delayed copy.
    assign sel        = swSync_q;
    assign cmdEvent   = validS_q & ~validDly_q;
    assign cmdHit     = cmdEvent && (addrS_q == CMD_ADDR);
    assign addEvent   = addS_q & ~addDly_q;
    assign selChanged = (swSync_q != selPrev_q);
    assign curVal     = chan_q[sel];

`ifdef SATURATE_ADD_EN
    assign incVal = (curVal == {WIDTH{1'b1}}) ? curVal : WIDTH'(curVal + 1'b1);
`else
    assign incVal = WIDTH'(curVal + 1'b1);
`endif

    // Next-state: a command hit outranks an add, and an add outranks a plain select reload.
    always_comb begin
        chan_d         = chan_q;
        ack_d          = 1'b0;
        dataOut_d      = dataOut_q;
        dataOutValid_d = 1'b0;
        if (cmdHit) begin
            chan_d[sel]    = dataS_q;
            ack_d          = 1'b1;
            dataOut_d      = dataS_q;
            dataOutValid_d = 1'b1;
        end else if (addEvent) begin
            chan_d[sel]    = incVal;
            dataOut_d      = incVal;
            dataOutValid_d = 1'b1;
        end else if (selChanged) begin
            dataOut_d      = curVal;
            dataOutValid_d = 1'b1;
        end
    end

    // Registers: input sampling, switch synchronizer, channel store and outputs.
    always_ff @(posedge clk) begin
        if (rst) begin
            swMeta_q       <= 2'b00;
            swSync_q       <= 2'b00;
            selPrev_q      <= 2'b00;
            validS_q       <= 1'b0;
            validDly_q     <= 1'b0;
            addS_q         <= 1'b0;
            addDly_q       <= 1'b0;
            addrS_q        <= '0;
            dataS_q        <= '0;
            for (int i = 0; i < 4; i++) begin
                chan_q[i] <= '0;
            end
            ack_q          <= 1'b0;
            dataOut_q      <= '0;
            dataOutValid_q <= 1'b0;
        end else begin
            swMeta_q       <= {SW1, SW0};
            swSync_q       <= swMeta_q;
            selPrev_q      <= swSync_q;
            validS_q       <= valid;
            validDly_q     <= validS_q;
            addS_q         <= add;
            addDly_q       <= addS_q;
            addrS_q        <= address;
            dataS_q        <= data;
            chan_q         <= chan_d;
            ack_q          <= ack_d;
            dataOut_q      <= dataOut_d;
            dataOutValid_q <= dataOutValid_d;
        end
    end

    assign ack            = ack_q;
    assign data_out       = dataOut_q;
    assign data_out_valid = dataOutValid_q;
    assign channel        = swSync_q;

endmodule

// File: tb/tb_channel_proc.sv
// Testbench for channel_proc: scenario tasks drive commands, adds and switch
// changes while a reference model pushes the expected data_out/ack results
// into a queue; a monitor pops and compares them on every data_out_valid.
module tb_channel_proc;

    logic       clk;
    logic       rst;
    logic       sw0;
    logic       sw1;
    logic       addIn;
    logic [3:0] cmdAddr;
    logic [3:0] cmdData;
    logic       cmdValid;
    logic       ackOut;
    logic [3:0] dataOut;
    logic       dataOutValid;
    logic [1:0] channelOut;

    typedef struct {
        logic       ackExp;
        logic [3:0] valExp;
    } sbEntry_t;

    sbEntry_t   sbQ[$];
    logic [3:0] model [4];
    logic [1:0] modelSel;
    int         compared;
    int         mismatched;

`ifdef SATURATE_ADD_EN
    localparam logic [3:0] WRAP_RESULT = 4'd15;
`else
    localparam logic [3:0] WRAP_RESULT = 4'd8;
`endif

    channel_proc dut (
        .clk            (clk),
        .rst            (rst),
        .SW0            (sw0),
        .SW1            (sw1),
        .add            (addIn),
        .address        (cmdAddr),
        .data           (cmdData),
        .valid          (cmdValid),
        .ack            (ackOut),
        .data_out       (dataOut),
        .data_out_valid (dataOutValid),
        .channel        (channelOut)
    );

    // Free-running 100 MHz clock.
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Scoreboard monitor: each data_out_valid strobe consumes one expectation.
    always @(posedge clk) begin
        sbEntry_t e;
        #1;
        if (!rst) begin
            if (dataOutValid) begin
                compared++;
                if (sbQ.size() == 0) begin
                    mismatched++;
                    $display("[TB] FAIL scoreboard_unexpected: data_out=%0d ack=%0b, expected no strobe", dataOut, ackOut);
                end else begin
                    e = sbQ.pop_front();
                    if (dataOut !== e.valExp || ackOut !== e.ackExp) begin
                        mismatched++;
                        $display("[TB] FAIL scoreboard_data: data_out=%0d ack=%0b, expected data_out=%0d ack=%0b",
                                 dataOut, ackOut, e.valExp, e.ackExp);
                    end
                end
            end else if (ackOut) begin
                compared++;
                mismatched++;
                $display("[TB] FAIL scoreboard_ack: ack=1 without data_out_valid, expected ack=0");
            end
        end
    end

    task automatic doCommand(input logic [3:0] a, input logic [3:0] d);
        @(negedge clk);
        cmdAddr  = a;
        cmdData  = d;
        cmdValid = 1'b1;
        if (a == 4'h2) begin
            model[modelSel] = d;
            sbQ.push_back('{1'b1, d});
        end
        @(negedge clk);
        cmdValid = 1'b0;
        repeat (3) @(negedge clk);
    endtask

    task automatic doAdd();
        @(negedge clk);
        addIn = 1'b1;
`ifdef SATURATE_ADD_EN
        if (model[modelSel] != 4'hF) model[modelSel] = model[modelSel] + 4'd1;
`else
        model[modelSel] = model[modelSel] + 4'd1;
`endif
        sbQ.push_back('{1'b0, model[modelSel]});
        @(negedge clk);
        addIn = 1'b0;
        repeat (3) @(negedge clk);
    endtask

    task automatic setSwitch(input logic [1:0] v);
        @(negedge clk);
        {sw1, sw0} = v;
        if (v != modelSel) sbQ.push_back('{1'b0, model[v]});
        modelSel = v;
        repeat (5) @(negedge clk);
    endtask

    task automatic test_reset();
        rst = 1'b1;
        repeat (3) @(negedge clk);
        compared += 4;
        if (ackOut !== 1'b0) begin mismatched++; $display("[TB] FAIL reset_ack: got %0b, expected 0", ackOut); end
        if (dataOut !== 4'd0) begin mismatched++; $display("[TB] FAIL reset_data_out: got %0d, expected 0", dataOut); end
        if (dataOutValid !== 1'b0) begin mismatched++; $display("[TB] FAIL reset_dov: got %0b, expected 0", dataOutValid); end
        if (channelOut !== 2'd0) begin mismatched++; $display("[TB] FAIL reset_channel: got %0d, expected 0", channelOut); end
        rst = 1'b0;
        repeat (2) @(negedge clk);
    endtask

    task automatic test_write_and_add();
        @(negedge clk);
        cmdAddr  = 4'h2;
        cmdData  = 4'd1;
        cmdValid = 1'b1;
        model[0] = 4'd1;
        sbQ.push_back('{1'b1, 4'd1});
        @(negedge clk);
        cmdValid = 1'b0;
        compared++;
        if (ackOut !== 1'b0) begin mismatched++; $display("[TB] FAIL ack_early: got %0b after 1 edge, expected 0", ackOut); end
        @(negedge clk);
        compared += 2;
        if (ackOut !== 1'b1) begin mismatched++; $display("[TB] FAIL ack_latency: got %0b after 2 edges, expected 1", ackOut); end
        if (dataOut !== 4'd1) begin mismatched++; $display("[TB] FAIL write_value: got %0d, expected 1", dataOut); end
        @(negedge clk);
        compared++;
        if (ackOut !== 1'b0) begin mismatched++; $display("[TB] FAIL ack_pulse: got %0b after 3 edges, expected 0", ackOut); end
        repeat (2) @(negedge clk);
        doAdd();
        compared += 2;
        if (dataOut !== 4'd2) begin mismatched++; $display("[TB] FAIL add_value: got %0d, expected 2", dataOut); end
        if (sbQ.size() != 0) begin mismatched++; $display("[TB] FAIL t1_pending: got %0d pending, expected 0", sbQ.size()); end
    endtask

    task automatic test_channel_latency();
        @(negedge clk);
        {sw1, sw0} = 2'b01;
        sbQ.push_back('{1'b0, model[1]});
        modelSel = 2'd1;
        @(negedge clk);
        compared++;
        if (channelOut !== 2'd0) begin mismatched++; $display("[TB] FAIL channel_early: got %0d after 1 edge, expected 0", channelOut); end
        @(negedge clk);
        compared++;
        if (channelOut !== 2'd1) begin mismatched++; $display("[TB] FAIL channel_latency: got %0d after 2 edges, expected 1", channelOut); end
        repeat (3) @(negedge clk);
        doCommand(4'h2, 4'd1);
        doCommand(4'h2, 4'd2);
        compared++;
        if (dataOut !== 4'd2) begin mismatched++; $display("[TB] FAIL ch1_write: got %0d, expected 2", dataOut); end
        setSwitch(2'd0);
        compared++;
        if (dataOut !== 4'd2) begin mismatched++; $display("[TB] FAIL ch0_kept: got %0d, expected 2", dataOut); end
        setSwitch(2'd1);
        compared++;
        if (sbQ.size() != 0) begin mismatched++; $display("[TB] FAIL t2_pending: got %0d pending, expected 0", sbQ.size()); end
    endtask

    task automatic test_wrap();
        setSwitch(2'd3);
        doCommand(4'h2, 4'd2);
        doCommand(4'h2, 4'd15);
        for (int i = 0; i < 9; i++) doAdd();
        compared++;
        if (dataOut !== WRAP_RESULT) begin mismatched++; $display("[TB] FAIL wrap_value: got %0d, expected %0d", dataOut, WRAP_RESULT); end
    endtask

    task automatic test_reselect();
        setSwitch(2'd1);
        for (int i = 0; i < 10; i++) doAdd();
        compared++;
        if (dataOut !== 4'd12) begin mismatched++; $display("[TB] FAIL ch1_adds: got %0d, expected 12", dataOut); end
        setSwitch(2'd3);
        compared++;
        if (dataOut !== WRAP_RESULT) begin mismatched++; $display("[TB] FAIL reselect_ch3: got %0d, expected %0d", dataOut, WRAP_RESULT); end
    endtask

    task automatic test_edge_priority();
        int ackCount;
        @(negedge clk);
        cmdAddr  = 4'h3;
        cmdData  = 4'd7;
        cmdValid = 1'b1;
        repeat (2) @(negedge clk);
        cmdValid = 1'b0;
        repeat (4) @(negedge clk);
        compared++;
        if (dataOut !== WRAP_RESULT) begin mismatched++; $display("[TB] FAIL wrong_addr: got %0d, expected %0d", dataOut, WRAP_RESULT); end
        @(negedge clk);
        cmdAddr  = 4'h2;
        cmdData  = 4'd5;
        cmdValid = 1'b1;
        addIn    = 1'b1;
        model[modelSel] = 4'd5;
        sbQ.push_back('{1'b1, 4'd5});
        ackCount = 0;
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            cmdValid = 1'b0;
            addIn    = 1'b0;
            if (ackOut === 1'b1) ackCount++;
        end
        compared += 2;
        if (ackCount != 1) begin mismatched++; $display("[TB] FAIL priority_ack_count: got %0d, expected 1", ackCount); end
        if (dataOut !== 4'd5) begin mismatched++; $display("[TB] FAIL priority_value: got %0d, expected 5", dataOut); end
    endtask

    task automatic test_mid_reset();
        setSwitch(2'd0);
        @(negedge clk);
        cmdAddr  = 4'h2;
        cmdData  = 4'd9;
        cmdValid = 1'b1;
        @(negedge clk);
        rst      = 1'b1;
        cmdValid = 1'b0;
        repeat (3) @(negedge clk);
        compared += 4;
        if (ackOut !== 1'b0) begin mismatched++; $display("[TB] FAIL midrst_ack: got %0b, expected 0", ackOut); end
        if (dataOut !== 4'd0) begin mismatched++; $display("[TB] FAIL midrst_data_out: got %0d, expected 0", dataOut); end
        if (dataOutValid !== 1'b0) begin mismatched++; $display("[TB] FAIL midrst_dov: got %0b, expected 0", dataOutValid); end
        if (channelOut !== 2'd0) begin mismatched++; $display("[TB] FAIL midrst_channel: got %0d, expected 0", channelOut); end
        rst = 1'b0;
        for (int i = 0; i < 4; i++) model[i] = 4'd0;
        repeat (4) @(negedge clk);
        compared++;
        if (sbQ.size() != 0) begin mismatched++; $display("[TB] FAIL midrst_pending: got %0d pending, expected 0", sbQ.size()); end
        setSwitch(2'd1);
        setSwitch(2'd2);
        setSwitch(2'd3);
        setSwitch(2'd0);
        doCommand(4'h2, 4'd3);
        doCommand(4'h2, 4'd15);
        compared++;
        if (dataOut !== 4'd15) begin mismatched++; $display("[TB] FAIL after_rst_write: got %0d, expected 15", dataOut); end
    endtask

    // Scenario sequence followed by the final drain check and summary.
    initial begin
        compared   = 0;
        mismatched = 0;
        rst        = 1'b1;
        sw0        = 1'b0;
        sw1        = 1'b0;
        addIn      = 1'b0;
        cmdAddr    = 4'h0;
        cmdData    = 4'h0;
        cmdValid   = 1'b0;
        modelSel   = 2'd0;
        for (int i = 0; i < 4; i++) model[i] = 4'd0;

        test_reset();
        test_write_and_add();
        test_channel_latency();
        test_wrap();
        test_reselect();
        test_edge_priority();
        test_mid_reset();

        repeat (5) @(negedge clk);
        compared++;
        if (sbQ.size() != 0) begin
            mismatched++;
            $display("[TB] FAIL final_drain: got %0d pending expectations, expected 0", sbQ.size());
        end
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
